// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate decode, operand capture, and an ID/EX register with load-use and flush control.
// Optional WB_BYPASS_EN forwards a same-cycle writeback into the captured operands instead of stalling.
module decode_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      if_valid,
  output logic                      if_ready,
  input  logic [31:0]               if_instr,
  input  logic [DATA_WIDTH-1:0]     if_pc,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic [DATA_WIDTH-1:0]     rs1_data,
  input  logic [DATA_WIDTH-1:0]     rs2_data,
  input  logic                      wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
  input  logic [DATA_WIDTH-1:0]     wb_rd_data,
  input  logic                      flush,
  input  logic                      ex_ready,
  output logic                      ex_valid,
  output logic [DATA_WIDTH-1:0]     ex_pc,
  output logic [DATA_WIDTH-1:0]     ex_rs1_data,
  output logic [DATA_WIDTH-1:0]     ex_rs2_data,
  output logic [DATA_WIDTH-1:0]     ex_imm,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [6:0]                ex_opcode,
  output logic [2:0]                ex_funct3,
  output logic                      ex_funct7b5,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write,
  output logic                      ex_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [6:0]                opcode;
  logic [REG_ADDR_WIDTH-1:0] rd_field;
  logic                      is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic                      is_load, is_store, is_opimm, is_op, legal;
  logic                      uses_rs1, uses_rs2;
  logic                      dec_reg_write, dec_mem_read, dec_mem_write;
  logic [REG_ADDR_WIDTH-1:0] dec_rd;
  logic [DATA_WIDTH-1:0]     dec_imm;
  logic [DATA_WIDTH-1:0]     op1, op2;
  logic                      load_use, wb_hazard, bubble, stall, accept;

  assign opcode   = if_instr[6:0];
  assign rd_field = if_instr[11:7];
  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];

  always_comb begin
    is_lui    = (opcode == OP_LUI);
    is_auipc  = (opcode == OP_AUIPC);
    is_jal    = (opcode == OP_JAL);
    is_jalr   = (opcode == OP_JALR);
    is_branch = (opcode == OP_BRANCH);
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
    is_opimm  = (opcode == OP_IMM);
    is_op     = (opcode == OP_REG);
    legal     = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store |
                is_opimm | is_op | (opcode == OP_FENCE) | (opcode == OP_SYSTEM);

    uses_rs1 = !(is_lui || is_auipc || is_jal);
    uses_rs2 = is_op || is_store || is_branch;

    dec_reg_write = (is_op || is_opimm || is_load || is_lui || is_auipc || is_jal || is_jalr) &&
                    (rd_field != '0);
    dec_mem_read  = is_load;
    dec_mem_write = is_store;
    dec_rd        = dec_reg_write ? rd_field : '0;

    if (is_store)
      dec_imm = {{(DATA_WIDTH-11){if_instr[31]}}, if_instr[30:25], if_instr[11:7]};
    else if (is_branch)
      dec_imm = {{(DATA_WIDTH-12){if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
    else if (is_lui || is_auipc)
      dec_imm = {{(DATA_WIDTH-31){if_instr[31]}}, if_instr[30:12], 12'b0};
    else if (is_jal)
      dec_imm = {{(DATA_WIDTH-20){if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
    else if (is_op)
      dec_imm = '0;
    else
      dec_imm = {{(DATA_WIDTH-11){if_instr[31]}}, if_instr[30:20]};
  end

  assign load_use = if_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                    ((uses_rs1 && (ex_rd == rs1_addr)) || (uses_rs2 && (ex_rd == rs2_addr)));

`ifdef WB_BYPASS_EN
  assign wb_hazard = 1'b0;
  assign op1 = (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs1_addr)) ? wb_rd_data : rs1_data;
  assign op2 = (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs2_addr)) ? wb_rd_data : rs2_data;
`else
  logic unused_wb_data;
  // Without forwarding, wait one cycle so the register file returns the written value.
  assign wb_hazard = if_valid && wb_reg_write && (wb_rd_addr != '0) &&
                     ((uses_rs1 && (wb_rd_addr == rs1_addr)) || (uses_rs2 && (wb_rd_addr == rs2_addr)));
  assign op1 = rs1_data;
  assign op2 = rs2_data;
  assign unused_wb_data = ^wb_rd_data;
`endif

  assign bubble   = load_use || wb_hazard;
  assign stall    = (ex_valid && !ex_ready) || bubble;
  assign if_ready = rst_n && !stall && !flush;
  assign accept   = if_valid && if_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rd        <= '0;
      ex_opcode    <= '0;
      ex_funct3    <= '0;
      ex_funct7b5  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (ex_valid && !ex_ready) begin
      ex_valid <= ex_valid;
    end else if (bubble) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid     <= 1'b1;
      ex_pc        <= if_pc;
      ex_rs1_data  <= op1;
      ex_rs2_data  <= op2;
      ex_imm       <= dec_imm;
      ex_rd        <= legal ? dec_rd : '0;
      ex_opcode    <= opcode;
      ex_funct3    <= if_instr[14:12];
      ex_funct7b5  <= if_instr[30];
      ex_reg_write <= legal && dec_reg_write;
      ex_mem_read  <= legal && dec_mem_read;
      ex_mem_write <= legal && dec_mem_write;
      ex_illegal   <= !legal;
    end else begin
      ex_valid <= 1'b0;
    end
  end

endmodule
